// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_pkg : shared types and defaults for the fetch unit          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package fetch_pkg;

    localparam int          DEFAULT_L        = 16;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | if_id_reg : fetch output register (valid/instruction/pc)          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module if_id_reg #(
    parameter int L = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         flush_i,
    input  logic [L-1:0] instr_i,
    input  logic [L-1:0] pc_i,
    output logic         valid_o,
    output logic [L-1:0] instr_o,
    output logic [L-1:0] pc_o
);

    logic         valid_q;
    logic [L-1:0] instr_q;
    logic [L-1:0] pc_q;

    // flush only drops the valid flag; the stale payload is never observed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit : PC sequencer with branch/halt and output handshake   |
// | Optional FetchCount counter enabled by FETCH_PERF_EN. Rev 1.0      |
// +------------------------------------------------------------------+
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int           L        = DEFAULT_L,
    parameter logic [L-1:0] RESET_PC = L'(DEFAULT_RESET_PC)
) (
    input  logic         Clock,
    input  logic         ResetN,
    output logic [L-1:0] Address,
    input  logic [L-1:0] Instruction,
    input  logic         BranchValid,
    input  logic [L-1:0] BranchTarget,
    input  logic         Halt,
    input  logic         OutReady,
`ifdef FETCH_PERF_EN
    output logic [31:0]  FetchCount,
`endif
    output logic         OutValid,
    output logic [L-1:0] OutInstruction,
    output logic [L-1:0] OutPc
);

    fetch_state_t state_q;
    logic [L-1:0] pc_q;
    logic [L-1:0] pc_d;
    logic         capture;
    logic         load;
    logic         accept;
    logic         flush;

    assign pc_d    = pc_q + {{(L-1){1'b0}}, 1'b1};
    assign capture = !OutValid || OutReady;
    assign load    = (state_q == RUN) && !BranchValid && !Halt && capture;
    assign accept  = OutValid && OutReady;
    // a word accepted without a replacement (halt/halted drain) must leave
    assign flush   = BranchValid || (accept && !load);
    assign Address = pc_q;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else if (BranchValid) begin
            state_q <= RUN;
            pc_q    <= BranchTarget;
        end else begin
            case (state_q)
                IDLE:    state_q <= RUN;
                RUN: begin
                    if (Halt) begin
                        state_q <= HALTED;
                    end else if (capture) begin
                        pc_q <= pc_d;
                    end
                end
                HALTED:  state_q <= HALTED;
                default: state_q <= IDLE;
            endcase
        end
    end

    if_id_reg #(
        .L (L)
    ) u_if_id_reg (
        .clk_i   (Clock),
        .rst_ni  (ResetN),
        .load_i  (load),
        .flush_i (flush),
        .instr_i (Instruction),
        .pc_i    (pc_q),
        .valid_o (OutValid),
        .instr_o (OutInstruction),
        .pc_o    (OutPc)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] count_q;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            count_q <= '0;
        end else if (accept) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign FetchCount = count_q;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_unit : directed scoreboard bench for fetch_unit           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_fetch_unit;

    logic        Clock = 1'b0;
    logic        ResetN;
    logic [15:0] Address;
    logic [15:0] Instruction;
    logic        BranchValid;
    logic [15:0] BranchTarget;
    logic        Halt;
    logic        OutReady;
    logic        OutValid;
    logic [15:0] OutInstruction;
    logic [15:0] OutPc;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount;
`endif

    int checks  = 0;
    int errors  = 0;
    int accepts = 0;
    logic [31:0] sb[$];

    always #5 Clock = ~Clock;

    assign Instruction = (Address <= 16'd30) ? Address : 16'd0;

    fetch_unit #(
        .L        (16),
        .RESET_PC (16'h0000)
    ) dut (
        .Clock          (Clock),
        .ResetN         (ResetN),
        .Address        (Address),
        .Instruction    (Instruction),
        .BranchValid    (BranchValid),
        .BranchTarget   (BranchTarget),
        .Halt           (Halt),
        .OutReady       (OutReady),
`ifdef FETCH_PERF_EN
        .FetchCount     (FetchCount),
`endif
        .OutValid       (OutValid),
        .OutInstruction (OutInstruction),
        .OutPc          (OutPc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc);
        logic [15:0] instr;
        instr = (pc <= 16'd30) ? pc : 16'd0;
        sb.push_back({instr, pc});
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_EN
        check("fetch_count", FetchCount, 32'(accepts));
`endif
    endtask

    // one clock; a word handed over at this edge is popped from the scoreboard
    task automatic tick();
        logic        acc;
        logic [31:0] word;
        logic [31:0] exp;
        acc  = OutValid && OutReady;
        word = {OutInstruction, OutPc};
        @(posedge Clock);
        #1;
        if (acc) begin
            accepts++;
            exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
            check("sb_word", word, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [15:0] pc,
                              input logic [15:0] ins, input logic [15:0] addr);
        check({tag, "_valid"}, 32'(OutValid), 32'(v));
        if (v) begin
            check({tag, "_pc"},    32'(OutPc), 32'(pc));
            check({tag, "_instr"}, 32'(OutInstruction), 32'(ins));
        end
        check({tag, "_addr"}, 32'(Address), 32'(addr));
    endtask

    initial begin
        ResetN       = 1'b0;
        BranchValid  = 1'b0;
        BranchTarget = 16'h0000;
        Halt         = 1'b0;
        OutReady     = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_valid", 32'(OutValid), 32'd0);
        check("rst_instr", 32'(OutInstruction), 32'd0);
        check("rst_pc",    32'(OutPc), 32'd0);
        check("rst_addr",  32'(Address), 32'd0);
        check_perf();

        ResetN = 1'b1;
        tick();
        expect_out("idle", 1'b0, 16'd0, 16'd0, 16'd0);
        tick();
        expect_out("first", 1'b1, 16'd0, 16'd0, 16'd1);

        for (int i = 1; i <= 5; i++) begin
            push(16'(i - 1));
            tick();
            expect_out("stream", 1'b1, 16'(i), 16'(i), 16'(i + 1));
        end

        OutReady = 1'b0;
        push(16'd5);
        repeat (3) begin
            tick();
            expect_out("stall", 1'b1, 16'd5, 16'd5, 16'd6);
        end
        check_perf();
        OutReady = 1'b1;
        tick();
        expect_out("resume", 1'b1, 16'd6, 16'd6, 16'd7);
        check_perf();
        push(16'd6);
        tick();
        expect_out("pre_br", 1'b1, 16'd7, 16'd7, 16'd8);

        push(16'd7);
        BranchValid  = 1'b1;
        BranchTarget = 16'd20;
        tick();
        expect_out("br_flush", 1'b0, 16'd0, 16'd0, 16'd20);
        BranchValid = 1'b0;
        tick();
        expect_out("br_target", 1'b1, 16'd20, 16'd20, 16'd21);

        push(16'd20);
        Halt         = 1'b1;
        BranchValid  = 1'b1;
        BranchTarget = 16'd30;
        tick();
        expect_out("br_wins", 1'b0, 16'd0, 16'd0, 16'd30);
        Halt        = 1'b0;
        BranchValid = 1'b0;
        tick();
        expect_out("fetch30", 1'b1, 16'd30, 16'd30, 16'd31);
        push(16'd30);
        tick();
        expect_out("fetch31", 1'b1, 16'd31, 16'd0, 16'd32);

        Halt     = 1'b1;
        OutReady = 1'b0;
        tick();
        expect_out("halt_hold", 1'b1, 16'd31, 16'd0, 16'd32);
        Halt = 1'b0;
        tick();
        expect_out("halted_hold", 1'b1, 16'd31, 16'd0, 16'd32);
        push(16'd31);
        OutReady = 1'b1;
        tick();
        expect_out("halt_drain", 1'b0, 16'd0, 16'd0, 16'd32);
        tick();
        expect_out("halted_idle", 1'b0, 16'd0, 16'd0, 16'd32);
        check_perf();

        BranchValid  = 1'b1;
        BranchTarget = 16'hFFFF;
        tick();
        expect_out("br_top", 1'b0, 16'd0, 16'd0, 16'hFFFF);
        BranchValid = 1'b0;
        tick();
        expect_out("top_word", 1'b1, 16'hFFFF, 16'd0, 16'h0000);
        push(16'hFFFF);
        tick();
        expect_out("wrap_word", 1'b1, 16'h0000, 16'd0, 16'h0001);
        check_perf();

        // asynchronous reset between edges discards the in-flight word
        #2;
        ResetN = 1'b0;
        #1;
        check("async_valid", 32'(OutValid), 32'd0);
        check("async_addr",  32'(Address), 32'd0);
        check("async_pc",    32'(OutPc), 32'd0);
        accepts = 0;
        check_perf();
        tick();
        ResetN = 1'b1;
        tick();
        expect_out("restart_idle", 1'b0, 16'd0, 16'd0, 16'd0);
        tick();
        expect_out("restart_first", 1'b1, 16'd0, 16'd0, 16'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter L, default 16: instruction and address width in bits.
REQ-002 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 ResetN  input  1  asynchronous, active-low reset.
REQ-005 Address  output  L  fetch address to instruction memory; combinationally equal to PC.
REQ-006 Instruction  input  L  combinational read data from instruction memory for Address.
REQ-007 BranchValid  input  1  redirect request, sampled at the clock edge.
REQ-008 BranchTarget  input  L  redirect target address, valid when BranchValid=1.
REQ-009 Halt  input  1  stop fetching, sampled at the clock edge.
REQ-010 OutReady  input  1  decoder accepts the output word this cycle.
REQ-011 OutValid  output  1  OutInstruction/OutPc hold a valid fetched word.
REQ-012 OutInstruction  output  L  registered fetched instruction.
REQ-013 OutPc  output  L  registered address of OutInstruction.
REQ-014 FetchCount  output  32  count of words accepted downstream; exists only when FETCH_PERF_EN is defined.

Function
REQ-015 The state machine SHALL have three states: IDLE, RUN and HALTED.
REQ-016 IDLE SHALL fetch nothing and SHALL go to RUN on the next edge.
REQ-017 In RUN, a capture occurs when OutValid=0 or OutReady=1.
REQ-018 On a capture edge: OutInstruction<=Instruction, OutPc<=PC, OutValid<=1, PC<=PC+1.
REQ-019 PC arithmetic is modulo 2^L: 0xFFFF+1 wraps to 0x0000 (L=16); the unit is one instruction per address.
REQ-020 In RUN with OutValid=1 and OutReady=0, PC and all output registers SHALL hold (no loss, no duplication).
REQ-021 OutValid SHALL fall only after acceptance with no new capture, or on a flush.
REQ-022 BranchValid=1 in any state: PC<=BranchTarget, OutValid<=0 (flush), state<=RUN; no capture that edge.
REQ-023 Priority on the same edge: BranchValid, then Halt, then capture.
REQ-024 Halt=1 in RUN without a branch: state<=HALTED, no capture; a pending OutValid word stays until accepted.
REQ-025 HALTED: PC holds; no capture; leaves only on BranchValid.
REQ-026 Latency: an instruction at Address on capture edge N appears on OutInstruction after edge N.

Reset
REQ-027 ResetN low SHALL immediately force: PC=RESET_PC, state=IDLE, OutValid=0, OutInstruction=0, OutPc=0, FetchCount=0.
REQ-028 Reset asserted mid-run SHALL discard any in-flight word; after release, operation restarts at REQ-016.

Configuration
REQ-029 Macro FETCH_PERF_EN defined: a 32-bit FetchCount increments on every edge with OutValid=1 and OutReady=1, wraps at 2^32, cleared by reset and not by flush.
REQ-030 Macro FETCH_PERF_EN undefined: the FetchCount port and counter logic are absent; all other behaviour is identical.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum typedef (IDLE, RUN, HALTED), the default width constant 16 and the default RESET_PC.
REQ-032 Sub-module if_id_reg SHALL hold the OutValid/OutInstruction/OutPc output register with load/flush/hold controls; fetch_unit holds the PC, FSM and counter.

Verification (memory model: address n returns n for 0..30, 0 otherwise)
REQ-033 Release reset, OutReady=1 -> OutValid=1 on the 2nd edge after release; OutInstruction/OutPc = 0,1,2,3 on consecutive cycles.
REQ-034 OutReady=0 for 3 cycles while OutInstruction=5 -> output holds 5, Address holds 6; OutReady=1 -> next word 6, FetchCount +1 per accept only.
REQ-035 BranchValid, BranchTarget=20 while OutInstruction=7 -> next cycle OutValid=0, Address=20; following cycle OutInstruction=20, OutPc=20.
REQ-036 Halt and BranchValid (target 30) on the same edge -> branch wins, state RUN; fetch 30 then 31 returns 0. Then Halt alone -> HALTED, Address frozen, pending word drains once.
REQ-037 Branch to 0xFFFF -> OutPc 0xFFFF then 0x0000; assert ResetN low mid-stream -> OutValid=0 immediately, Address=RESET_PC.
